md5_pad: RTL
============

Name: md5_pad

Overview:
- Streaming MD5 message padder and block former; sits in front of md5_ctl.
- Accepts an arbitrary-length byte message in beats of IN_BYTES bytes.
- Appends the MD5 padding: 0x80, zero fill, then the 64-bit little-endian bit length.
- Emits 16-word blocks on md5_ctl's rdy/msg word interface, 16 consecutive cycles per block, with first/final block flags.

Parameters:
- IN_BYTES, 4: bytes per input beat; legal values 1, 2, 4, 8.
- LEN_W, 64: width of the bit-length counter, 32..64; bits above LEN_W are sent as 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_data  in  8*IN_BYTES  message bytes; msg-order byte 0 in bits [0:7], MSB-first numbering.
- in_nbytes  in  clog2(IN_BYTES+1)  valid bytes in the beat. Must equal IN_BYTES unless in_last. Range 0..IN_BYTES on last; 0 means the empty tail.
- in_last  in  1  beat ends the message.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- ds_busy  in  1  md5_ctl busy_o; no block emission starts while high.
- out_rdy  out  1  word strobe to md5_ctl rdy.
- out_msg  out  32  word to md5_ctl msg, bits [0:31].
- out_first  out  1  high with every word of the first block of a message.
- out_final  out  1  high with every word of the last block of a message.

Behaviour:
- Reset (async): all outputs 0, byte offset 0, length 0, buffer contents don't-care.
  - Partial block discarded; out_rdy drops immediately.
  - in_ready rises on the first clk edge after rst deasserts.
- FSM states: FILL, PAD, EMIT, WAIT.
- FILL:
  - in_ready=1; accepted bytes are written at byte offset off (0..63) of the 16x32 buffer.
  - len += 8*in_nbytes, modulo 2^LEN_W.
  - Beats never straddle a block because 64 % IN_BYTES == 0.
  - Non-last beat filling off to 64 -> WAIT (block full, more data follows).
  - Last beat -> PAD.
- PAD (in_ready=0), one cycle; final offset f = off after the last beat:
  - f<64: byte f=0x80, bytes f+1..63 zero.
    - If f<=55: bytes 56..63 = len little-endian; block marked final.
    - Else: no length in this block; a second block follows.
  - f==64: block emitted as-is, then a pad-only block is formed: byte0=0x80, zeros, length at 56..63.
  - Second/pad-only block: all zero except the 0x80 (f==64 case only) and the length at bytes 56..63; marked final.
- WAIT: holds until ds_busy==0, then EMIT on the next edge.
- EMIT, 16 cycles:
  - out_rdy=1; out_msg = buffer word 0..15 in order; in_ready=0.
  - After word 15: next is the pending second block (via WAIT), else FILL with off=0.
  - After a final block, len is also cleared to 0.
- Flags:
  - out_first: set for the first block after reset or after a final block.
  - out_final: set for the final block only.
  - Both are 0 when out_rdy=0.
- Latency: from the accepting edge of the last beat, PAD takes 1 cycle, then WAIT takes at least 1 cycle. With ds_busy low, the first out_rdy is the 3rd cycle after acceptance.
- ds_busy rising during EMIT is ignored; a burst is never split.
- in_valid while in_ready=0: held by the producer, not lost.
- An in_nbytes violation on a non-last beat is undefined; the bench must not drive it.

Decomposition:
- defines.h gains MD5_BLK_WORDS=16, MD5_BLK_BYTES=64, MD5_PAD_BYTE=8'h80, MD5_LEN_OFS=56, and state encodings MD5PAD_FILL/PAD/WAIT/EMIT.
- Sub-module md5_pad_buf: 16x32 byte-writable register file. Inputs: byte offset, IN_BYTES-wide write with per-byte enables, clear-tail-from-offset, length insert. Read port indexed by the emit counter.

Test Plan:
1. IN_BYTES=4, one beat in_last=1, nbytes=0 -> one block: w0=0x80000000, w1..w15=0. out_first=out_final=1. md5_ctl hash d41d8cd98f00b204e9800998ecf8427e.
2. IN_BYTES=4, beat 0x61616161, nbytes=4, last -> w0=0x61616161, w1=0x80000000, w14=0x20000000, others 0. Hash 74b87337454200d4d33f80c4663dc5e5. First out_rdy 3 cycles after acceptance.
3. 56 bytes 'a', IN_BYTES=4:
   - Block0: w0..13=0x61616161, w14=0x80000000, w15=0; out_first=1, out_final=0.
   - Block1: w0..13=0, w14=0xC0010000, w15=0; out_final=1.
4. IN_BYTES=1, bytes 61,62,63, last on 63 -> w0=0x61626380, w14=0x18000000. in_ready=0 for all 16 EMIT cycles.
5. 64-byte message -> data block unchanged (out_final=0), then pad block w0=0x80000000, w14=0x00020000. ds_busy held high 20 cycles before the second block -> out_rdy stays 0 until 1 cycle after release, then 16 consecutive words.
6. rst pulse after 7 accepted words -> out_rdy never asserts. Next "aaaa" message reproduces scenario 2 words with out_first=1.

Source files
------------

// File: rtl/md5_pad_pkg.sv
// Shared constants, FSM encoding and word packing for the MD5 padder.
package md5_pad_pkg;

   localparam int MD5_BLK_WORDS = 16;
   localparam int MD5_BLK_BYTES = 64;
   localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
   localparam int MD5_LEN_OFS = 56;

   typedef enum logic [1:0] {
      MD5PAD_FILL = 2'd0,
      MD5PAD_PAD  = 2'd1,
      MD5PAD_WAIT = 2'd2,
      MD5PAD_EMIT = 2'd3
   } md5pad_state_t;

   // Message byte 0 lands in the most significant byte of the word.
   function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
      return {b0, b1, b2, b3};
   endfunction

endpackage

// File: rtl/md5_pad_if.sv
// Byte-beat input side plus the word strobe interface towards md5_ctl.
interface md5_pad_if #(parameter int IN_BYTES = 4);

   localparam int NB_W = $clog2(IN_BYTES + 1);

   logic                  in_valid;
   logic [8*IN_BYTES-1:0] in_data;
   logic [NB_W-1:0]       in_nbytes;
   logic                  in_last;
   logic                  in_ready;
   logic                  ds_busy;
   logic                  out_rdy;
   logic [31:0]           out_msg;
   logic                  out_first;
   logic                  out_final;

   modport master (
      output in_valid, in_data, in_nbytes, in_last, ds_busy,
      input  in_ready, out_rdy, out_msg, out_first, out_final
   );

   modport slave (
      input  in_valid, in_data, in_nbytes, in_last, ds_busy,
      output in_ready, out_rdy, out_msg, out_first, out_final
   );

endinterface

// File: rtl/md5_pad_buf.sv
// 64-byte block buffer: byte-lane writes at any offset, tail clear, length insert.
// Contents are don't-care after reset, so the array carries no reset.
module md5_pad_buf
   import md5_pad_pkg::*;
#(
   parameter int IN_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [5:0]            wr_off,
   input  logic [8*IN_BYTES-1:0] wr_data,
   input  logic [IN_BYTES-1:0]   wr_be,
   input  logic                  clr_en,
   input  logic [6:0]            clr_off,
   input  logic                  len_en,
   input  logic [63:0]           len_val,
   input  logic [3:0]            rd_idx,
   output logic [31:0]           rd_word
);

   logic [7:0] mem [MD5_BLK_BYTES];
   logic [5:0] base;

   // Later assignments take priority: clear, then data write, then length.
   always_ff @(posedge clk) begin
      for (int b = 0; b < MD5_BLK_BYTES; b++) begin
         if (clr_en && (7'(b) >= clr_off))
            mem[b] <= 8'h00;
         for (int k = 0; k < IN_BYTES; k++) begin
            if (wr_en && wr_be[k] && ((7'(wr_off) + 7'(k)) == 7'(b)))
               mem[b] <= wr_data[8*(IN_BYTES-1-k) +: 8];
         end
      end
      for (int b = 0; b < 8; b++) begin
         if (len_en)
            mem[MD5_LEN_OFS+b] <= len_val[8*b +: 8];
      end
   end

   assign base    = {rd_idx, 2'b00};
   assign rd_word = pack_word(mem[base], mem[base + 6'd1], mem[base + 6'd2], mem[base + 6'd3]);

endmodule

// File: rtl/md5_pad.sv
// Streaming MD5 padder: gathers byte beats into 64-byte blocks, appends 0x80/zeros/length,
// and bursts each block as 16 consecutive words once ds_busy is low.
module md5_pad
   import md5_pad_pkg::*;
#(
   parameter int IN_BYTES = 4,
   parameter int LEN_W    = 64
) (
   input  logic     clk,
   input  logic     rst,
   md5_pad_if.slave bus
);

   md5pad_state_t         state;
   logic [6:0]            off;
   logic [LEN_W-1:0]      len;
   logic [3:0]            widx;
   logic                  blk_final;
   logic                  pending;
   logic                  pend_pad0;
   logic                  first_blk;
   logic                  in_ready_q;
   logic                  out_rdy_q;
   logic                  out_first_q;
   logic                  out_final_q;
   logic [31:0]           out_msg_q;

   logic                  accept;
   logic [6:0]            nb;
   logic [6:0]            off_nx;
   logic [LEN_W-1:0]      len_nx;
   logic [8*IN_BYTES-1:0] pad_dat;

   logic                  wr_en;
   logic [5:0]            wr_off;
   logic [8*IN_BYTES-1:0] wr_data;
   logic [IN_BYTES-1:0]   wr_be;
   logic                  clr_en;
   logic [6:0]            clr_off;
   logic                  len_en;
   logic [63:0]           len_val;
   logic [3:0]            rd_idx;
   logic [31:0]           rd_word;

   assign accept  = bus.in_valid && in_ready_q;
   assign nb      = 7'(bus.in_nbytes);
   assign off_nx  = off + nb;
   assign len_nx  = len + (LEN_W'(nb) << 3);
   assign len_val = 64'(len);
   assign rd_idx  = (state == MD5PAD_EMIT) ? widx + 4'd1 : 4'd0;

   always_comb begin
      pad_dat = '0;
      pad_dat[8*IN_BYTES-1 -: 8] = MD5_PAD_BYTE;
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_off  = off[5:0];
      wr_data = '0;
      wr_be   = '0;
      clr_en  = 1'b0;
      clr_off = 7'd64;
      len_en  = 1'b0;
      case (state)
         MD5PAD_FILL: begin
            wr_en   = accept;
            wr_data = bus.in_data;
            for (int k = 0; k < IN_BYTES; k++)
               wr_be[k] = (7'(k) < nb);
         end
         MD5PAD_PAD: begin
            if (off < 7'(MD5_BLK_BYTES)) begin
               clr_en   = 1'b1;
               clr_off  = off + 7'd1;
               wr_en    = 1'b1;
               wr_data  = pad_dat;
               wr_be[0] = 1'b1;
               len_en   = (off < 7'(MD5_LEN_OFS));
            end
         end
         MD5PAD_EMIT: begin
            // Form the follow-on length block right after the last word has been read out.
            if ((widx == 4'(MD5_BLK_WORDS - 1)) && pending) begin
               clr_en   = 1'b1;
               clr_off  = 7'd0;
               wr_en    = pend_pad0;
               wr_off   = 6'd0;
               wr_data  = pad_dat;
               wr_be[0] = 1'b1;
               len_en   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   md5_pad_buf #(.IN_BYTES(IN_BYTES)) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_off  (wr_off),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .clr_en  (clr_en),
      .clr_off (clr_off),
      .len_en  (len_en),
      .len_val (len_val),
      .rd_idx  (rd_idx),
      .rd_word (rd_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= MD5PAD_FILL;
         off         <= '0;
         len         <= '0;
         widx        <= '0;
         blk_final   <= 1'b0;
         pending     <= 1'b0;
         pend_pad0   <= 1'b0;
         first_blk   <= 1'b1;
         in_ready_q  <= 1'b0;
         out_rdy_q   <= 1'b0;
         out_first_q <= 1'b0;
         out_final_q <= 1'b0;
         out_msg_q   <= '0;
      end else begin
         case (state)
            MD5PAD_FILL: begin
               if (accept) begin
                  off <= off_nx;
                  len <= len_nx;
                  if (bus.in_last) begin
                     state      <= MD5PAD_PAD;
                     in_ready_q <= 1'b0;
                  end else if (off_nx == 7'(MD5_BLK_BYTES)) begin
                     state      <= MD5PAD_WAIT;
                     in_ready_q <= 1'b0;
                     blk_final  <= 1'b0;
                     pending    <= 1'b0;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            MD5PAD_PAD: begin
               state     <= MD5PAD_WAIT;
               blk_final <= (off < 7'(MD5_LEN_OFS));
               pending   <= (off >= 7'(MD5_LEN_OFS));
               pend_pad0 <= (off == 7'(MD5_BLK_BYTES));
            end
            MD5PAD_WAIT: begin
               if (!bus.ds_busy) begin
                  state       <= MD5PAD_EMIT;
                  widx        <= '0;
                  out_rdy_q   <= 1'b1;
                  out_msg_q   <= rd_word;
                  out_first_q <= first_blk;
                  out_final_q <= blk_final;
               end
            end
            MD5PAD_EMIT: begin
               if (widx == 4'(MD5_BLK_WORDS - 1)) begin
                  out_rdy_q   <= 1'b0;
                  out_msg_q   <= '0;
                  out_first_q <= 1'b0;
                  out_final_q <= 1'b0;
                  first_blk   <= blk_final;
                  if (pending) begin
                     state     <= MD5PAD_WAIT;
                     pending   <= 1'b0;
                     blk_final <= 1'b1;
                  end else begin
                     state      <= MD5PAD_FILL;
                     off        <= '0;
                     in_ready_q <= 1'b1;
                     if (blk_final)
                        len <= '0;
                  end
               end else begin
                  widx      <= widx + 4'd1;
                  out_msg_q <= rd_word;
               end
            end
            default: state <= MD5PAD_FILL;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_rdy   = out_rdy_q;
   assign bus.out_msg   = out_msg_q;
   assign bus.out_first = out_first_q;
   assign bus.out_final = out_final_q;

endmodule
